// File: rtl/mux_n_arb.sv
// N-channel word multiplexer with valid/ready handshakes and a single registered output stage.
// MODE 0 forwards the channel picked by sel; MODE 1 arbitrates round-robin across valid channels.
module mux_n_arb #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int MODE     = 0,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] chan_q, chan_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic [SEL_W-1:0] gnt;
  logic             gntValid;
  logic             loadEn;
  logic             xferEn;
  logic [WIDTH-1:0] word;
  logic [SEL_W-1:0] ptrNext;

  // sel is only consulted in fixed mode
  logic unusedSel;
  assign unusedSel = ^sel;

  // Round-robin scan runs from the far end back towards ptr so the closest valid channel wins.
  always_comb begin
    gnt      = '0;
    gntValid = 1'b0;
    if (MODE == 0) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          gnt      = SEL_W'(i);
          gntValid = 1'b1;
        end
      end
    end else begin
      for (int k = CHANNELS - 1; k >= 0; k--) begin
        if (in_valid[(int'(ptr_q) + k) % CHANNELS]) begin
          gnt      = SEL_W'((int'(ptr_q) + k) % CHANNELS);
          gntValid = 1'b1;
        end
      end
    end
  end

  always_comb begin
    loadEn  = !valid_q || out_ready;
    xferEn  = !reset && loadEn && gntValid;
    word    = '0;
    ptrNext = (gnt == SEL_W'(CHANNELS - 1)) ? '0 : gnt + 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      in_ready[i] = xferEn && (gnt == SEL_W'(i));
      if (gnt == SEL_W'(i)) begin
        word = in_data[i*WIDTH +: WIDTH];
      end
    end

    data_d  = data_q;
    chan_d  = chan_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (xferEn) begin
      data_d  = word;
      chan_d  = gnt;
      valid_d = 1'b1;
      if (MODE == 1) begin
        ptr_d = ptrNext;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      data_q  <= data_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_data  = data_q;
  assign out_chan  = chan_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_n_arb.sv
// Randomised and directed bench for mux_n_arb: three builds (fixed/4, fixed/8, round-robin/4)
// checked every cycle against a transaction-level model of grant, output register and pointer.
module tb_mux_n_arb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]   vld  [3];
  logic [127:0] dat  [3];
  logic [2:0]   sel  [3];
  logic         ordy [3];

  logic [3:0]  rdy0, rdy2;
  logic [7:0]  rdy1;
  logic [15:0] data0, data1, data2;
  logic [1:0]  chan0, chan2;
  logic [2:0]  chan1;
  logic        ov0, ov1, ov2;

  mux_n_arb #(.WIDTH(16), .CHANNELS(4), .MODE(0)) dutFix4 (
    .clk(clk), .reset(rst), .in_data(dat[0][63:0]), .in_valid(vld[0][3:0]),
    .in_ready(rdy0), .sel(sel[0][1:0]), .out_data(data0), .out_chan(chan0),
    .out_valid(ov0), .out_ready(ordy[0]));

  mux_n_arb #(.WIDTH(16), .CHANNELS(8), .MODE(0)) dutFix8 (
    .clk(clk), .reset(rst), .in_data(dat[1]), .in_valid(vld[1]),
    .in_ready(rdy1), .sel(sel[1]), .out_data(data1), .out_chan(chan1),
    .out_valid(ov1), .out_ready(ordy[1]));

  mux_n_arb #(.WIDTH(16), .CHANNELS(4), .MODE(1)) dutRr4 (
    .clk(clk), .reset(rst), .in_data(dat[2][63:0]), .in_valid(vld[2][3:0]),
    .in_ready(rdy2), .sel(sel[2][1:0]), .out_data(data2), .out_chan(chan2),
    .out_valid(ov2), .out_ready(ordy[2]));

  int nCh  [3] = '{4, 8, 4};
  int mode [3] = '{0, 0, 1};

  // Reference model state per instance
  bit          mValid [3];
  logic [15:0] mData  [3];
  int          mChan  [3];
  int          mPtr   [3];
  bit          known;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] actRdy(int n);
    return (n == 0) ? {4'h0, rdy0} : (n == 1) ? rdy1 : {4'h0, rdy2};
  endfunction
  function automatic logic [15:0] actData(int n);
    return (n == 0) ? data0 : (n == 1) ? data1 : data2;
  endfunction
  function automatic int actChan(int n);
    return (n == 0) ? int'(chan0) : (n == 1) ? int'(chan1) : int'(chan2);
  endfunction
  function automatic logic actValid(int n);
    return (n == 0) ? ov0 : (n == 1) ? ov1 : ov2;
  endfunction

  // Returns the granted channel or -1 when nothing can be granted
  function automatic int grantOf(int n);
    if (mode[n] == 0) begin
      if (int'(sel[n]) < nCh[n] && vld[n][sel[n]]) return int'(sel[n]);
      return -1;
    end
    for (int k = 0; k < nCh[n]; k++) begin
      if (vld[n][(mPtr[n] + k) % nCh[n]]) return (mPtr[n] + k) % nCh[n];
    end
    return -1;
  endfunction

  // Compares one cycle of all instances against the model, advances the model, moves to next negedge
  task automatic applyStimulus();
    int g;
    bit le;
    logic [7:0] expRdy;
    #1;
    for (int n = 0; n < 3; n++) begin
      g      = grantOf(n);
      le     = !mValid[n] || ordy[n];
      expRdy = (!rst && le && g >= 0) ? 8'(1 << g) : 8'h00;
      checkOutput($sformatf("inReady%0d", n), 64'(actRdy(n)), 64'(expRdy));
      if (known) begin
        checkOutput($sformatf("outValid%0d", n), 64'(actValid(n)), 64'(mValid[n]));
        checkOutput($sformatf("outData%0d", n), 64'(actData(n)), 64'(mData[n]));
        checkOutput($sformatf("outChan%0d", n), 64'(actChan(n)), 64'(mChan[n]));
      end
      if (rst) begin
        mValid[n] = 1'b0;
        mData[n]  = 16'h0;
        mChan[n]  = 0;
        mPtr[n]   = 0;
      end else if (expRdy != 8'h00) begin
        mValid[n] = 1'b1;
        mData[n]  = dat[n][g*16 +: 16];
        mChan[n]  = g;
        if (mode[n] == 1) mPtr[n] = (g + 1) % nCh[n];
      end else if (mValid[n] && ordy[n]) begin
        mValid[n] = 1'b0;
      end
    end
    if (rst) known = 1'b1;
    @(negedge clk);
  endtask

  int rrSeq [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    known = 1'b0;
    rst   = 1'b1;
    for (int n = 0; n < 3; n++) begin
      vld[n]  = 8'hFF & ((nCh[n] == 8) ? 8'hFF : 8'h0F);
      dat[n]  = '0;
      sel[n]  = '0;
      ordy[n] = 1'b1;
    end
    @(negedge clk);

    // Reset with every channel requesting
    applyStimulus();
    checkOutput("t1 rdyInReset", 64'(rdy0), 64'h0);
    applyStimulus();
    rst = 1'b0;
    for (int n = 0; n < 3; n++) vld[n] = 8'h00;
    checkOutput("t1 outValid", 64'(ov0), 64'h0);
    checkOutput("t1 outData", 64'(data0), 64'h0);
    applyStimulus();

    // Fixed select and one-cycle latency
    sel[0] = 3'd2;
    vld[0] = 8'h04;
    dat[0][32 +: 16] = 16'hBEEF;
    #1;
    checkOutput("t2 rdySel2", 64'(rdy0), 64'h4);
    applyStimulus();
    checkOutput("t2 dataBeef", 64'(data0), 64'hBEEF);
    checkOutput("t2 chan2", 64'(chan0), 64'h2);
    checkOutput("t2 valid", 64'(ov0), 64'h1);
    vld[0] = 8'h00;
    sel[1] = 3'd1;
    vld[1] = 8'h02;
    dat[1][16 +: 16] = 16'hA5A5;
    applyStimulus();
    checkOutput("t2 c8 valid", 64'(ov1), 64'h1);
    sel[1] = 3'd5;
    vld[1] = 8'h01;
    applyStimulus();
    checkOutput("t2 sel5 noXfer", 64'(ov1), 64'h0);
    vld[1] = 8'h00;

    // Backpressure holds the word, then drain and reload on the same edge
    sel[0] = 3'd0;
    vld[0] = 8'h01;
    dat[0][0 +: 16] = 16'h1234;
    applyStimulus();
    ordy[0] = 1'b0;
    repeat (3) begin
      sel[0] = 3'($urandom_range(0, 3));
      vld[0] = 8'($urandom_range(1, 15));
      dat[0] = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus();
      checkOutput("t3 holdData", 64'(data0), 64'h1234);
      checkOutput("t3 holdRdy", 64'(rdy0), 64'h0);
    end
    ordy[0] = 1'b1;
    sel[0]  = 3'd1;
    vld[0]  = 8'h02;
    dat[0][16 +: 16] = 16'h5678;
    #1;
    checkOutput("t3 rdyDrain", 64'(rdy0), 64'h2);
    applyStimulus();
    checkOutput("t3 reload", 64'(data0), 64'h5678);
    checkOutput("t3 noBubble", 64'(ov0), 64'h1);
    vld[0] = 8'h00;
    applyStimulus();

    // Round-robin fairness with every channel requesting
    for (int c = 0; c < 4; c++) dat[2][c*16 +: 16] = 16'hC000 + 16'(c);
    vld[2]  = 8'h0F;
    ordy[2] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus();
      checkOutput($sformatf("t4 rrChan%0d", i), 64'(chan2), 64'(rrSeq[i]));
      checkOutput($sformatf("t4 rrValid%0d", i), 64'(ov2), 64'h1);
    end

    // Skip and wrap, then a late requester
    vld[2] = 8'h04;
    applyStimulus();
    checkOutput("t5 ch2", 64'(chan2), 64'h2);
    vld[2] = 8'h03;
    applyStimulus();
    checkOutput("t5 wrap0", 64'(chan2), 64'h0);
    applyStimulus();
    checkOutput("t5 then1", 64'(chan2), 64'h1);
    applyStimulus();
    checkOutput("t5 then0", 64'(chan2), 64'h0);
    vld[2] = 8'h0B;
    applyStimulus();
    checkOutput("t5 late1", 64'(chan2), 64'h1);
    applyStimulus();
    checkOutput("t5 late3", 64'(chan2), 64'h3);

    // Reset during a stall; pointer must return to 0
    vld[2] = 8'h02;
    sel[0] = 3'd0;
    vld[0] = 8'h01;
    applyStimulus();
    checkOutput("t6 preChan1", 64'(chan2), 64'h1);
    ordy[0] = 1'b0;
    ordy[2] = 1'b0;
    vld[2]  = 8'h00;
    applyStimulus();
    checkOutput("t6 stalled", 64'(ov2), 64'h1);
    rst = 1'b1;
    applyStimulus();
    checkOutput("t6 ovRr", 64'(ov2), 64'h0);
    checkOutput("t6 chanRr", 64'(chan2), 64'h0);
    checkOutput("t6 ovFix", 64'(ov0), 64'h0);
    rst     = 1'b0;
    vld[0]  = 8'h00;
    vld[2]  = 8'h0A;
    ordy[2] = 1'b1;
    applyStimulus();
    checkOutput("t6 firstGrant", 64'(chan2), 64'h1);

    // Random traffic against the model
    repeat (400) begin
      rst = ($urandom_range(0, 49) == 0);
      for (int n = 0; n < 3; n++) begin
        vld[n]  = 8'($urandom) & ((nCh[n] == 8) ? 8'hFF : 8'h0F);
        sel[n]  = 3'($urandom_range(0, nCh[n] - 1));
        dat[n]  = {$urandom, $urandom, $urandom, $urandom};
        ordy[n] = ($urandom_range(0, 3) != 0);
      end
      applyStimulus();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
